// File: rtl/mem_interface.sv
// Memory interface stage: owns MAR/MDR and sequences wait-stated reads/writes on a sync single-port RAM.
// Optional build macro MEM_ADDR_CHECK_EN: out-of-range requests complete without a RAM strobe and set err.
module mem_interface #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1,
    parameter int MEM_DEPTH   = 512
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              ReadEn,
    input  logic              Write,
    output logic [DATA_W-1:0] MDR_q,
    output logic [ADDR_W-1:0] MAR_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    // state   | meaning
    // IDLE    | no transaction, accepts requests and MDR bus loads
    // RD_WAIT | mem_re held while the wait counter runs down
    // RD_CAP  | capture mem_rdata into MDR, pulse done
    // WR_WAIT | mem_we held while the wait counter runs down, done on terminal count
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP, WR_WAIT} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mar_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              rd_zero_q, rd_zero_d;
    logic              wr_prev_q;
    logic              read_req, wr_edge, mdr_load, addr_oor;

    assign read_req = MDRin & ReadEn;
    assign wr_edge  = Write & ~wr_prev_q;
    assign mdr_load = MDRin & ~ReadEn;

`ifdef MEM_ADDR_CHECK_EN
    assign addr_oor = (32'(mar_q) >= MEM_DEPTH);
`else
    // Range check compiled out; the depth term only keeps the parameter referenced.
    assign addr_oor = 1'b0 && (MEM_DEPTH > 0);
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            mar_q     <= '0;
            addr_q    <= '0;
            mdr_q     <= '0;
            wdata_q   <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b0;
            wr_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            mdr_q     <= mdr_d;
            wdata_q   <= wdata_d;
            re_q      <= re_d;
            we_q      <= we_d;
            err_q     <= err_d;
            rd_zero_q <= rd_zero_d;
            wr_prev_q <= Write;
            if (MARin) mar_q <= BusMuxOut[ADDR_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        mdr_d     = mdr_q;
        wdata_d   = wdata_q;
        re_d      = re_q;
        we_d      = we_q;
        err_d     = err_q;
        rd_zero_d = rd_zero_q;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (mdr_load) mdr_d = BusMuxOut;
                if (read_req) begin
                    addr_d    = mar_q;
                    cnt_d     = 4'(WAIT_STATES);
                    re_d      = 1'b1;
                    rd_zero_d = 1'b0;
                    state_d   = RD_WAIT;
                    if (wr_edge) err_d = 1'b1;
                    if (addr_oor) begin
                        re_d      = 1'b0;
                        rd_zero_d = 1'b1;
                        err_d     = 1'b1;
                        state_d   = RD_CAP;
                    end
                end else if (wr_edge) begin
                    addr_d  = mar_q;
                    wdata_d = mdr_q;
                    cnt_d   = 4'(WAIT_STATES);
                    we_d    = 1'b1;
                    state_d = WR_WAIT;
                    // Out-of-range write: one silent cycle in WR_WAIT gives the done pulse.
                    if (addr_oor) begin
                        we_d  = 1'b0;
                        cnt_d = 4'd0;
                        err_d = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    re_d    = 1'b0;
                    state_d = RD_CAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_CAP: begin
                mdr_d   = rd_zero_q ? '0 : mem_rdata;
                done    = 1'b1;
                state_d = IDLE;
            end
            WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    we_d    = 1'b0;
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && (read_req || wr_edge || mdr_load)) err_d = 1'b1;
    end

    assign MDR_q     = mdr_q;
    assign MAR_q     = mar_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: random reads/writes against a word-array memory model plus directed corner cases.
module tb_mem_interface;
    localparam int WS = 1;
`ifdef MEM_ADDR_CHECK_EN
    localparam int DEPTH = 256;
`else
    localparam int DEPTH = 512;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] BusMuxOut = '0;
    logic        MARin = 1'b0, MDRin = 1'b0, ReadEn = 1'b0, Write = 1'b0;
    logic [31:0] MDR_q, mem_wdata, mem_rdata;
    logic [8:0]  MAR_q, mem_addr;
    logic        mem_re, mem_we, busy, done, err;

    logic [31:0] ram     [512];
    logic [31:0] exp_mem [512];
    int n_chk = 0, n_bad = 0;
    int re_cyc = 0, we_cyc = 0, done_cnt = 0;

    mem_interface #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(WS), .MEM_DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
        .ReadEn(ReadEn), .Write(Write), .MDR_q(MDR_q), .MAR_q(MAR_q), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 Clock = ~Clock;

    // Synchronous RAM: read data valid the cycle after mem_re.
    always @(posedge Clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    always @(negedge Clock) begin
        if (mem_re) re_cyc++;
        if (mem_we) we_cyc++;
        if (done)   done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic set_mar(input logic [8:0] a);
        BusMuxOut = {23'd0, a};
        MARin = 1'b1;
        tick();
        MARin = 1'b0;
    endtask

    task automatic set_mdr(input logic [31:0] d);
        BusMuxOut = d;
        MDRin = 1'b1;
        tick();
        MDRin = 1'b0;
    endtask

    task automatic do_read(input logic [8:0] a, input bit poke, input logic [8:0] pa, input bit again);
        int r0, d0;
        set_mar(a);
        r0 = re_cyc;
        d0 = done_cnt;
        MDRin = 1'b1; ReadEn = 1'b1;
        tick();
        MDRin = 1'b0; ReadEn = 1'b0;
        if (poke) begin
            BusMuxOut = {23'd0, pa};
            MARin = 1'b1;
            if (again) begin MDRin = 1'b1; ReadEn = 1'b1; end
            tick();
            MARin = 1'b0; MDRin = 1'b0; ReadEn = 1'b0;
            repeat (WS + 1) tick();
        end else begin
            repeat (WS + 2) tick();
        end
        chk("rd_mdr", MDR_q, exp_mem[a]);
        chk("rd_re_cycles", 32'(re_cyc - r0), 32'(WS + 1));
        chk("rd_done", 32'(done_cnt - d0), 32'd1);
        chk("rd_busy", {31'd0, busy}, 32'd0);
        chk("rd_addr", {23'd0, mem_addr}, {23'd0, a});
        chk("rd_mar", {23'd0, MAR_q}, {23'd0, poke ? pa : a});
    endtask

    task automatic do_write(input logic [8:0] a, input logic [31:0] d, input int hold);
        int w0, d0;
        set_mdr(d);
        set_mar(a);
        w0 = we_cyc;
        d0 = done_cnt;
        Write = 1'b1;
        repeat (hold) tick();
        Write = 1'b0;
        repeat (WS + 2) tick();
        exp_mem[a] = d;
        chk("wr_ram", ram[a], exp_mem[a]);
        chk("wr_we_cycles", 32'(we_cyc - w0), 32'(WS + 1));
        chk("wr_done", 32'(done_cnt - d0), 32'd1);
        chk("wr_addr", {23'd0, mem_addr}, {23'd0, a});
        chk("wr_wdata", mem_wdata, d);
        chk("wr_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [8:0]  a, pa;
        logic [31:0] d;
        int r0, w0, d0;

        for (int i = 0; i < 512; i++) begin
            ram[i]     = $urandom;
            exp_mem[i] = ram[i];
        end
        ram[5] = 32'hDEADBEEF; exp_mem[5] = 32'hDEADBEEF;
        repeat (2) tick();
        Reset = 1'b1;
        tick();

        chk("rst_mdr", MDR_q, 32'd0);
        chk("rst_mar", {23'd0, MAR_q}, 32'd0);
        chk("rst_addr", {23'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_strobes", {29'd0, mem_re, mem_we, busy}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);

        // Read latency: MDR must still be old two edges after the request, new on the third.
        set_mar(9'h005);
        r0 = re_cyc; d0 = done_cnt;
        MDRin = 1'b1; ReadEn = 1'b1;
        tick();
        MDRin = 1'b0; ReadEn = 1'b0;
        chk("lat_busy", {31'd0, busy}, 32'd1);
        repeat (WS + 1) tick();
        chk("lat_early", MDR_q, 32'd0);
        tick();
        chk("lat_mdr", MDR_q, 32'hDEADBEEF);
        chk("lat_re_cycles", 32'(re_cyc - r0), 32'd2);
        chk("lat_done", 32'(done_cnt - d0), 32'd1);

        // Held Write must produce a single transaction.
        do_write(9'h010, 32'h12345678, 4);

        for (int t = 0; t < 40; t++) begin
            a  = 9'($urandom_range(DEPTH - 1));
            pa = 9'($urandom_range(511));
            if ($urandom_range(1) == 1)
                do_read(a, $urandom_range(1) == 1, pa, 1'b0);
            else
                do_write(a, $urandom, $urandom_range(1, 5));
        end
        chk("rand_err_clear", {31'd0, err}, 32'd0);

        // Second read while busy is dropped; MAR update still lands.
        do_read(9'h033, 1'b1, 9'h020, 1'b1);
        chk("busy_req_err", {31'd0, err}, 32'd1);

        // Reset asserted mid-read clears everything immediately, no done pulse.
        set_mar(9'h044);
        MDRin = 1'b1; ReadEn = 1'b1;
        tick();
        MDRin = 1'b0; ReadEn = 1'b0;
        d0 = done_cnt;
        #1 Reset = 1'b0;
        #1;
        chk("arst_strobes", {29'd0, mem_re, mem_we, busy}, 32'd0);
        chk("arst_regs", MDR_q | {23'd0, MAR_q} | {23'd0, mem_addr}, 32'd0);
        chk("arst_err", {30'd0, done, err}, 32'd0);
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
        do_read(9'h000, 1'b0, 9'h000, 1'b0);
        chk("arst_err_after", {31'd0, err}, 32'd0);

        // Read and Write edge together: read wins, write dropped.
        set_mar(9'h07A);
        w0 = we_cyc; r0 = re_cyc;
        MDRin = 1'b1; ReadEn = 1'b1; Write = 1'b1;
        tick();
        MDRin = 1'b0; ReadEn = 1'b0; Write = 1'b0;
        repeat (WS + 2) tick();
        chk("coll_we", 32'(we_cyc - w0), 32'd0);
        chk("coll_re", 32'(re_cyc - r0), 32'(WS + 1));
        chk("coll_mdr", MDR_q, exp_mem[9'h07A]);
        chk("coll_err", {31'd0, err}, 32'd1);

`ifdef MEM_ADDR_CHECK_EN
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        d = $urandom | 32'h1;
        set_mdr(d);
        set_mar(9'h1FF);
        r0 = re_cyc; d0 = done_cnt;
        MDRin = 1'b1; ReadEn = 1'b1;
        tick();
        MDRin = 1'b0; ReadEn = 1'b0;
        chk("oor_done", {31'd0, done}, 32'd1);
        tick();
        chk("oor_mdr", MDR_q, 32'd0);
        chk("oor_re", 32'(re_cyc - r0), 32'd0);
        chk("oor_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("oor_err", {31'd0, err}, 32'd1);
        chk("oor_busy", {31'd0, busy}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
